// File: rtl/cnt_pkg.sv
// Shared constants and types for the signed 10-bit event counter family.
// Used by the counter, its checker and the BCD display converter.
//   CNT_W / BCD_W       : counter sample width and packed 3-digit BCD width
//   CNT_MIN / CNT_MAX   : legal counter window (inclusive, signed)
//   CNT_INV             : forbidden counter value
//   CNT_RST             : counter reset value
//   conv_state_t        : state encoding of the BCD converter FSM
package cnt_pkg;

    localparam int CNT_W   = 10;
    localparam int BCD_W   = 12;

    localparam int CNT_MIN = -230;
    localparam int CNT_MAX = 235;
    localparam int CNT_INV = -11;
    localparam int CNT_RST = -50;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/cnt_bcd_converter_if.sv
// Handshake bundle between the counter sample producer, the BCD converter
// and the display/logging consumer.
//   in_valid / in_ready  : sample handshake (producer -> converter)
//   cnt                  : signed counter sample
//   out_valid / out_ready: result handshake (converter -> consumer)
//   sign, bcd, range_err : conversion result
// modport slave  : the converter side
// modport master : the environment (producer + consumer) side
interface cnt_bcd_converter_if;
    import cnt_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [CNT_W-1:0] cnt;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sign;
    logic [BCD_W-1:0]        bcd;
    logic                    range_err;

    modport slave (
        input  in_valid,
        input  cnt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sign,
        output bcd,
        output range_err
    );

    modport master (
        output in_valid,
        output cnt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sign,
        input  bcd,
        input  range_err
    );

endinterface

// File: rtl/cnt_bcd_converter_bcd_digit_adj.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
//   d : current BCD digit
//   q : corrected digit (only meaningful for d <= 9)
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/cnt_bcd_converter.sv
// Converts one signed counter sample at a time into sign + 3 packed BCD
// digits of its magnitude using a sequential double-dabble engine
// (one iteration per clock, 10 iterations per sample). Also flags samples
// outside [MIN, MAX] or equal to INV; flagged samples are still converted.
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-low reset
//   bus : handshake bundle (slave side), see cnt_bcd_converter_if
// Parameters MIN / MAX / INV : legal window and forbidden value.
module cnt_bcd_converter
    import cnt_pkg::*;
#(
    parameter int MIN = CNT_MIN,
    parameter int MAX = CNT_MAX,
    parameter int INV = CNT_INV
) (
    input  logic               clk,
    input  logic               rst,
    cnt_bcd_converter_if.slave bus
);

    // Limits narrowed to the sample width so the compares stay signed 10-bit.
    localparam logic signed [CNT_W-1:0] MIN_V = MIN[CNT_W-1:0];
    localparam logic signed [CNT_W-1:0] MAX_V = MAX[CNT_W-1:0];
    localparam logic signed [CNT_W-1:0] INV_V = INV[CNT_W-1:0];

    conv_state_t            state;
    conv_state_t            next_state;
    logic [3:0]             iter;
    logic [CNT_W-1:0]       mag;
    logic [BCD_W-1:0]       scratch;
    logic                   sign_q;
    logic                   err_q;

    logic signed [CNT_W:0]  cnt_ext;
    logic [CNT_W:0]         mag_wide;
    logic                   cnt_err;
    logic [BCD_W-1:0]       adj;
    logic                   unused_bits;

    // Magnitude is formed one bit wider than the sample so that -512
    // negates to +512 without wrapping; the result then fits in 10 bits.
    assign cnt_ext  = {bus.cnt[CNT_W-1], bus.cnt};
    assign mag_wide = cnt_ext[CNT_W] ? CNT_W'(0) - cnt_ext : cnt_ext;

    assign cnt_err  = (bus.cnt < MIN_V) || (bus.cnt > MAX_V) || (bus.cnt == INV_V);

    // Per-digit add-3 correction applied before every shift.
    bcd_digit_adj u_adj_ones (
        .d (scratch[3:0]),
        .q (adj[3:0])
    );

    bcd_digit_adj u_adj_tens (
        .d (scratch[7:4]),
        .q (adj[7:4])
    );

    bcd_digit_adj u_adj_hundreds (
        .d (scratch[11:8]),
        .q (adj[11:8])
    );

    // The top magnitude bit is always zero after negation and the top BCD
    // bit is shifted out; neither carries information.
    assign unused_bits = ^{mag_wide[CNT_W], adj[BCD_W-1]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the handshake outputs, which depend only on state.
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (iter == 4'd9) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture the sample on acceptance, then run one double-dabble
    // iteration per SHIFT cycle. In DONE everything holds so the result stays
    // stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag     <= '0;
            scratch <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            iter    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q  <= bus.cnt[CNT_W-1];
                        mag     <= mag_wide[CNT_W-1:0];
                        err_q   <= cnt_err;
                        scratch <= '0;
                        iter    <= 4'd0;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BCD_W-2:0], mag[CNT_W-1]};
                    mag     <= {mag[CNT_W-2:0], 1'b0};
                    iter    <= iter + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sign      = sign_q;
    assign bus.bcd       = scratch;
    assign bus.range_err = err_q;

endmodule

// File: doc/cnt_bcd_converter.md
# cnt_bcd_converter

Downstream stage of the signed 10-bit event counter. Accepts one counter sample at a time over a valid/ready handshake and converts its magnitude to three packed BCD digits plus a sign bit, using a sequential shift-and-add-3 (double-dabble) engine. It also flags samples that fall outside the legal counter window or equal the forbidden value. Results drive the display/logging path.

## Interface
- MIN, -230: lowest legal counter value (signed).
- MAX, 235: highest legal counter value (signed).
- INV, -11: forbidden counter value (signed).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low; asserting it forces all state to reset values immediately.
- in_valid  in  1  `cnt` holds a sample to convert.
- in_ready  out  1  block can accept a sample this cycle.
- cnt  in  signed[9:0]  counter sample.
- out_valid  out  1  result outputs are valid.
- out_ready  in  1  consumer takes the result this cycle.
- sign  out  1  1 = sample was negative.
- bcd  out  [11:0]  magnitude as BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- range_err  out  1  sample < MIN, > MAX, or == INV.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch sign = cnt[9];
  - latch mag = |cnt| as 10-bit unsigned, so -512 gives 512;
  - latch range_err from the full signed compare against MIN, MAX and INV;
  - clear the BCD scratch register, set iteration counter to 0, go to SHIFT.
- SHIFT: one double-dabble iteration per cycle.
  - Each BCD digit >= 5 gets +3.
  - Then {bcd_scratch, mag} shifts left by 1.
  - After iteration 9 (10 total), go to DONE.
- DONE: out_valid=1; sign, bcd and range_err are stable. On out_ready, go to IDLE.
- Out-of-range and INV samples are still converted in full. range_err is informational only.
- in_ready=0 in SHIFT and DONE. in_valid is ignored there and there is no bypass, so at most one sample is in flight.
- Arithmetic:
  - magnitude is computed in 11 bits before truncating to 10, so -512 does not overflow;
  - the BCD scratch register is 12 bits; max magnitude 512 fits in 3 digits.
- Reset values: in_ready=1, out_valid=0, sign=0, bcd=12'h000, range_err=0, iteration counter=0.
- Reset mid-operation (SHIFT or DONE) aborts the conversion and discards the result. The first post-reset conversion must be correct.

## Timing
- Acceptance edge E0 (IDLE, in_valid=1).
- SHIFT occupies edges E1..E10; the state becomes DONE at E10.
- out_valid is high from just after E10. Latency is 10 cycles from acceptance to valid.
- The result is consumed at the first edge where out_valid && out_ready; in_ready is high from the next cycle.
- Minimum initiation interval is 12 cycles (accept, 10 shifts, one DONE cycle with out_ready=1).
- Outputs are registered; there is no combinational path from in_valid or cnt to any output.
- in_ready depends only on state.

## Structure
- Shared package cnt_pkg holds:
  - CNT_W=10, BCD_W=12;
  - CNT_MIN=-230, CNT_MAX=235, CNT_INV=-11, CNT_RST=-50 (also used by the counter and its checker);
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t.
- The parameter defaults come from the package constants.
- One sub-module, bcd_digit_adj: combinational 4-bit "add 3 if >= 5", instantiated three times.

## Test plan
- Counter reset value: cnt=-50 accepted, out_ready=1 → out_valid 10 cycles later with sign=1, bcd=12'h050, range_err=0; in_ready high again the following cycle.
- Upper boundary: cnt=235 → sign=0, bcd=12'h235, range_err=0. Then cnt=236 → bcd=12'h236, range_err=1.
- Forbidden and extremes:
  - cnt=-11 → sign=1, bcd=12'h011, range_err=1;
  - cnt=-512 → sign=1, bcd=12'h512, range_err=1;
  - cnt=0 → sign=0, bcd=12'h000, range_err=0.
- Backpressure: cnt=-230 converted with out_ready=0 for 5 cycles → out_valid, sign=1, bcd=12'h230 held stable; in_ready=0 throughout. A second in_valid with cnt=100 during the stall is not accepted. After out_ready=1 it is accepted and gives bcd=12'h100.
- Reset mid-SHIFT: drop rst at iteration 4 of cnt=-195 → outputs immediately at reset values, state IDLE. After release, cnt=-195 converts to sign=1, bcd=12'h195.
- Back-to-back stream of counter-style values (-50, -45, …, step 5 up to -16, then -6) with out_ready=1 → every result matches, one conversion per 12 cycles, none dropped or duplicated.
